// File: rtl/decode_stage_pkg.sv
// Shared definitions for the instruction-decode stage.
// Holds the IR field bit positions and the immediate-extension mode encodings
// used by decode_stage, its register file and anything that builds
// instruction words for it.
package decode_stage_pkg;

  // IR field map
  localparam int OPC_HI = 31;
  localparam int OPC_LO = 26;
  localparam int RS_HI  = 25;
  localparam int RS_LO  = 21;
  localparam int RD_HI  = 20;
  localparam int RD_LO  = 16;
  localparam int RT_HI  = 15;
  localparam int RT_LO  = 11;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;

  // Immediate extension modes
  localparam logic [1:0] IMM_SEXT = 2'b00;  // sign-extend imm16
  localparam logic [1:0] IMM_ZEXT = 2'b01;  // zero-extend imm16
  localparam logic [1:0] IMM_LUI  = 2'b10;  // imm16 in the upper half
  localparam logic [1:0] IMM_BR   = 2'b11;  // sign-extended word offset (x4)

endpackage

// File: rtl/decode_stage_if.sv
// Bus between the fetch/write-back side and the decode stage.
//
// Signal semantics: there is no valid/ready handshake on this bus. Every
// input is sampled on each rising clock edge; ir_we and rf_we are single-edge
// strobes that act on the edge where they are high, and the outputs
// (ir_out, rf_a, rf_b, immed) are registers that are valid at all times
// after reset.
//
// Ports:
//   instr     fetch -> decode   instruction word
//   ir_we     fetch -> decode   load IR from instr this edge
//   rt_sel    fetch -> decode   rf_b address select (0 = rt, 1 = rd)
//   imm_mode  fetch -> decode   immediate extension mode
//   rf_we     wb    -> decode   register-file write enable
//   rf_waddr  wb    -> decode   register-file write address
//   rf_wdata  wb    -> decode   register-file write data
//   ir_out    decode -> *       current IR
//   rf_a      decode -> exec    registered rs operand
//   rf_b      decode -> exec    registered rt/rd operand
//   immed     decode -> fetch   registered extended immediate
interface decode_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  logic [31:0]       instr;
  logic              ir_we;
  logic              rt_sel;
  logic [1:0]        imm_mode;
  logic              rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [31:0]       ir_out;
  logic [DATA_W-1:0] rf_a;
  logic [DATA_W-1:0] rf_b;
  logic [DATA_W-1:0] immed;

  // Upstream side (fetch stage / write-back / testbench)
  modport master (
    output instr, ir_we, rt_sel, imm_mode, rf_we, rf_waddr, rf_wdata,
    input  ir_out, rf_a, rf_b, immed
  );

  // Decode stage side
  modport slave (
    input  instr, ir_we, rt_sel, imm_mode, rf_we, rf_waddr, rf_wdata,
    output ir_out, rf_a, rf_b, immed
  );
endinterface

// File: rtl/decode_stage_reg_file.sv
// Register file for the decode stage: 2**REG_AW x DATA_W, two combinational
// read ports, one synchronous write port.
// r0 has no storage and always reads zero; writes to it are dropped.
// Each read port forwards the write data when the same non-zero register is
// being written on this edge, so a registered read downstream captures the
// new value instead of the stale one.
//
// Ports:
//   clk, reset        clock, asynchronous active-high clear of all registers
//   we, waddr, wdata  write port
//   raddr_a, rdata_a  read port A
//   raddr_b, rdata_b  read port B
module decode_stage_reg_file #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] raddr_a,
  input  logic [REG_AW-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);

  localparam int NREGS = 2 ** REG_AW;

  logic [DATA_W-1:0] mem [1:NREGS-1];
  logic              wr_live;

  assign wr_live = we && (waddr != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 1; i < NREGS; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_live) begin
      mem[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata_a = '0;
    if (raddr_a != '0) begin
      rdata_a = (wr_live && (waddr == raddr_a)) ? wdata : mem[raddr_a];
    end
  end

  always_comb begin
    rdata_b = '0;
    if (raddr_b != '0) begin
      rdata_b = (wr_live && (waddr == raddr_b)) ? wdata : mem[raddr_b];
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Instruction-decode stage.
// Holds the instruction register, the register file and the immediate
// extender. Operands and the extended immediate are registered every edge
// from the current IR, so an instruction loaded at edge N has its operands
// and immediate on the outputs after edge N+1.
//
// Ports:
//   clk    clock, all state updates on the rising edge
//   reset  asynchronous active-high clear of IR, register file and outputs
//   bus    decode_stage_if.slave (instr/strobes/write-back in, IR and
//          operands out)
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic          clk,
  input  logic          reset,
  decode_stage_if.slave bus
);

  logic [31:0]       ir_q;
  logic [DATA_W-1:0] rf_a_q;
  logic [DATA_W-1:0] rf_b_q;
  logic [DATA_W-1:0] immed_q;

  logic [REG_AW-1:0] raddr_a;
  logic [REG_AW-1:0] raddr_b;
  logic [DATA_W-1:0] rdata_a;
  logic [DATA_W-1:0] rdata_b;
  logic [15:0]       imm16;
  logic [DATA_W-1:0] imm_sext;
  logic [DATA_W-1:0] imm_zext;
  logic [DATA_W-1:0] imm_next;

  // Reads always use the IR as it stands before this edge, even when ir_we
  // loads a new instruction on the same edge.
  assign raddr_a = ir_q[RS_HI:RS_LO];
  assign raddr_b = bus.rt_sel ? ir_q[RD_HI:RD_LO] : ir_q[RT_HI:RT_LO];

  decode_stage_reg_file #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_reg_file (
    .clk     (clk),
    .reset   (reset),
    .we      (bus.rf_we),
    .waddr   (bus.rf_waddr),
    .wdata   (bus.rf_wdata),
    .raddr_a (raddr_a),
    .raddr_b (raddr_b),
    .rdata_a (rdata_a),
    .rdata_b (rdata_b)
  );

  assign imm16    = ir_q[IMM_HI:IMM_LO];
  assign imm_sext = {{(DATA_W-16){imm16[15]}}, imm16};
  assign imm_zext = {{(DATA_W-16){1'b0}}, imm16};

  // Shifts are done at DATA_W, so bits pushed past the MSB are discarded.
  always_comb begin
    imm_next = imm_sext;
    case (bus.imm_mode)
      IMM_SEXT: imm_next = imm_sext;
      IMM_ZEXT: imm_next = imm_zext;
      IMM_LUI:  imm_next = imm_zext << 16;
      IMM_BR:   imm_next = imm_sext << 2;
      default:  imm_next = imm_sext;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir_q    <= '0;
      rf_a_q  <= '0;
      rf_b_q  <= '0;
      immed_q <= '0;
    end else begin
      if (bus.ir_we) begin
        ir_q <= bus.instr;
      end
      rf_a_q  <= rdata_a;
      rf_b_q  <= rdata_b;
      immed_q <= imm_next;
    end
  end

  assign bus.ir_out = ir_q;
  assign bus.rf_a   = rf_a_q;
  assign bus.rf_b   = rf_b_q;
  assign bus.immed  = immed_q;

endmodule
